scroll_scheduler: RTL and testbench

Per-frame scroll sequencer for the ground and obstacle layers. Detects the vsync rising edge and gates motion on the game state. Each running frame it advances a shared horizontal offset modulo the pattern period, and ramps scroll speed over time. Drives the offset consumed by the ground renderer and the frame strobe used by obstacle/score logic.

---
 rtl/scroll_scheduler.sv | 107 ++++++++++
 tb/tb_scroll_scheduler.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/scroll_scheduler.sv
// Per-frame scroll sequencer: on each vsync rising edge while running, advances the
// ground/obstacle offset modulo PERIOD and ramps scroll speed every RAMP_FRAMES frames.
module scroll_scheduler #(
  parameter int unsigned PERIOD      = 160,
  parameter int unsigned SPEED_INIT  = 6,
  parameter int unsigned SPEED_MAX   = 12,
  parameter int unsigned RAMP_FRAMES = 600,
  parameter int unsigned POS_W       = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             vsync,
  input  logic [1:0]       state,
  output logic [POS_W-1:0] pos,
  output logic [3:0]       speed,
  output logic             frame_tick,
  output logic             running
);

  localparam int unsigned RAMP_W = (RAMP_FRAMES > 1) ? $clog2(RAMP_FRAMES) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  localparam logic [POS_W:0]    PERIOD_W     = (POS_W+1)'(PERIOD);
  localparam logic [3:0]        SPEED_INIT_W = 4'(SPEED_INIT);
  localparam logic [3:0]        SPEED_MAX_W  = 4'(SPEED_MAX);
  localparam logic [RAMP_W-1:0] RAMP_LAST    = RAMP_W'(RAMP_FRAMES - 1);

  logic [1:0]        fsm_q, fsm_d;
  logic              vsync_q;
  logic [POS_W-1:0]  pos_q, pos_d;
  logic [3:0]        speed_q, speed_d;
  logic [RAMP_W-1:0] ramp_q, ramp_d;
  logic              tick_q, tick_d;
  logic              running_q, running_d;
  logic              vs_rise_c;
  logic [POS_W:0]    sum_c;

  // Next state follows the game-state input directly; 01 and 10 both mean running.
  always_comb begin
    fsm_d = ST_RUN;
    case (state)
      2'b00:   fsm_d = ST_IDLE;
      2'b11:   fsm_d = ST_HALT;
      default: fsm_d = ST_RUN;
    endcase
  end

  // Frame update and speed ramp; decisions use the FSM value registered before this edge.
  always_comb begin
    vs_rise_c = vsync & ~vsync_q;
    sum_c     = (POS_W+1)'(pos_q) + (POS_W+1)'(speed_q);
    pos_d     = pos_q;
    speed_d   = speed_q;
    ramp_d    = ramp_q;
    tick_d    = 1'b0;
    running_d = (fsm_d == ST_RUN);
    case (fsm_q)
      ST_IDLE: begin
        speed_d = SPEED_INIT_W;
        ramp_d  = '0;
      end
      ST_RUN: begin
        if (vs_rise_c) begin
          pos_d  = (sum_c >= PERIOD_W) ? POS_W'(sum_c - PERIOD_W) : POS_W'(sum_c);
          tick_d = 1'b1;
          if (ramp_q == RAMP_LAST) begin
            ramp_d  = '0;
            speed_d = (speed_q < SPEED_MAX_W) ? speed_q + 4'd1 : SPEED_MAX_W;
          end else begin
            ramp_d = ramp_q + RAMP_W'(1);
          end
        end
      end
      default: ;
    endcase
  end

  // vsync history resets high so a vsync already asserted at reset release is not an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q     <= ST_IDLE;
      vsync_q   <= 1'b1;
      pos_q     <= '0;
      speed_q   <= SPEED_INIT_W;
      ramp_q    <= '0;
      tick_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      fsm_q     <= fsm_d;
      vsync_q   <= vsync;
      pos_q     <= pos_d;
      speed_q   <= speed_d;
      ramp_q    <= ramp_d;
      tick_q    <= tick_d;
      running_q <= running_d;
    end
  end

  assign pos        = pos_q;
  assign speed      = speed_q;
  assign frame_tick = tick_q;
  assign running    = running_q;

endmodule

// File: tb/tb_scroll_scheduler.sv
// Directed bench for scroll_scheduler: a default instance and a fast-ramp instance
// share clock, reset and stimulus.
module tb_scroll_scheduler;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       vsync = 1'b1;
  logic [1:0] state = 2'b01;

  logic [9:0] pos_a, pos_r;
  logic [3:0] speed_a, speed_r;
  logic       tick_a, tick_r, run_a, run_r;

  int n_checks = 0;
  int n_fail   = 0;
  int tick_cnt_a = 0;
  int tick_cnt_r = 0;

  int exp_a, exp_r, spd_r, cnt_r, base;

  scroll_scheduler dut_a (
    .clk(clk), .rst_n(rst_n), .vsync(vsync), .state(state),
    .pos(pos_a), .speed(speed_a), .frame_tick(tick_a), .running(run_a)
  );

  scroll_scheduler #(.RAMP_FRAMES(4)) dut_r (
    .clk(clk), .rst_n(rst_n), .vsync(vsync), .state(state),
    .pos(pos_r), .speed(speed_r), .frame_tick(tick_r), .running(run_r)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (tick_a) tick_cnt_a++;
    if (tick_r) tick_cnt_r++;
  end

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // One vsync pulse; returns at the negedge right after the update edge.
  task automatic frame();
    @(negedge clk) vsync = 1'b1;
    @(negedge clk) vsync = 1'b0;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1;
    check("rst_pos", pos_a, 0);
    check("rst_speed", speed_a, 6);
    check("rst_tick", tick_a, 0);
    check("rst_running", run_a, 0);

    // vsync held high across reset release must not count as an edge
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("hold_pos", pos_a, 0);
    check("hold_ticks", tick_cnt_a, 0);
    check("hold_running", run_a, 1);
    vsync = 1'b0;
    @(negedge clk) vsync = 1'b1;
    @(negedge clk);
    check("first_pos", pos_a, 6);
    check("first_tick", tick_a, 1);
    check("first_speed", speed_a, 6);
    vsync = 1'b0;
    @(negedge clk);
    check("first_tick_clear", tick_a, 0);
    check("first_tick_cnt", tick_cnt_a, 1);

    // wrap: 27 more frames from pos 6
    exp_a = 6;
    base  = tick_cnt_a;
    for (int i = 0; i < 27; i++) begin
      frame();
      exp_a = (exp_a + 6) % 160;
      check("wrap_pos", pos_a, exp_a);
    end
    check("wrap_end", pos_a, 8);
    @(negedge clk);
    check("wrap_ticks", tick_cnt_a - base, 27);

    // ramp on the RAMP_FRAMES=4 instance
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(negedge clk);
    exp_a = 0; exp_r = 0; spd_r = 6; cnt_r = 0;
    for (int i = 1; i <= 40; i++) begin
      frame();
      exp_r = (exp_r + spd_r) % 160;
      exp_a = (exp_a + 6) % 160;
      if (cnt_r == 3) begin
        cnt_r = 0;
        if (spd_r < 12) spd_r++;
      end else begin
        cnt_r++;
      end
      check("ramp_pos", pos_r, exp_r);
      if (i == 4)  check("ramp_speed_f4", speed_r, 7);
      if (i == 5)  check("ramp_pos_f5", pos_r, 31);
      if (i == 23) check("ramp_speed_f23", speed_r, 11);
      if (i == 24) check("ramp_speed_f24", speed_r, 12);
      if (i == 40) check("ramp_speed_f40", speed_r, 12);
    end
    check("ramp_a_speed", speed_a, 6);
    check("ramp_a_pos", pos_a, exp_a);

    // halt freezes everything
    @(negedge clk) state = 2'b11;
    @(negedge clk);
    base = tick_cnt_r;
    repeat (5) frame();
    @(negedge clk);
    check("halt_pos_r", pos_r, exp_r);
    check("halt_speed_r", speed_r, 12);
    check("halt_pos_a", pos_a, exp_a);
    check("halt_running", run_r, 0);
    check("halt_ticks", tick_cnt_r - base, 0);

    // idle restores speed, keeps pos
    state = 2'b00;
    repeat (3) @(negedge clk);
    check("idle_speed", speed_r, 6);
    check("idle_pos", pos_r, exp_r);
    check("idle_running", run_r, 0);
    state = 2'b01;
    repeat (2) @(negedge clk);
    frame();
    exp_r = (exp_r + 6) % 160;
    exp_a = (exp_a + 6) % 160;
    check("resume_pos_r", pos_r, exp_r);
    check("resume_pos_a", pos_a, exp_a);

    // asynchronous reset between clock edges, while frame_tick is high
    @(negedge clk) vsync = 1'b1;
    @(posedge clk);
    #2;
    exp_a = (exp_a + 6) % 160;
    check("pre_rst_pos", pos_a, exp_a);
    check("pre_rst_tick", tick_a, 1);
    rst_n = 1'b0;
    #1;
    check("arst_pos", pos_a, 0);
    check("arst_speed", speed_a, 6);
    check("arst_tick", tick_a, 0);
    check("arst_running", run_a, 0);
    @(negedge clk);
    vsync = 1'b0;
    state = 2'b00;
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // state change coincident with vsync rise: no update that frame
    state = 2'b01;
    vsync = 1'b1;
    @(negedge clk);
    check("sim_pos", pos_a, 0);
    check("sim_tick", tick_a, 0);
    check("sim_running", run_a, 1);
    vsync = 1'b0;
    @(negedge clk);
    frame();
    check("sim_next_pos", pos_a, 6);
    check("sim_next_tick", tick_a, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
